// File: rtl/button_pkg.sv
// Shared types and defaults for the button conditioner: channel output modes
// and the state-bit update rule used by every channel.
// Purely declarative; no latency or flow control of its own.
package button_pkg;

    typedef enum logic [1:0] {
        MODE_MOMENTARY = 2'd0,
        MODE_TOGGLE    = 2'd1,
        MODE_ONESHOT   = 2'd2,
        MODE_LATCH     = 2'd3
    } mode_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 4;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 16;

    // Clear beats a toggle, but a press beats clear when latching.
    function automatic logic next_st(
        input mode_e mode,
        input logic  st,
        input logic  press,
        input logic  clear
    );
        logic nxt;
        nxt = st;
        case (mode)
            MODE_TOGGLE: begin
                if (clear) begin
                    nxt = 1'b0;
                end else if (press) begin
                    nxt = ~st;
                end
            end
            MODE_LATCH: begin
                if (press) begin
                    nxt = 1'b1;
                end else if (clear) begin
                    nxt = 1'b0;
                end
            end
            default: begin
                if (clear) begin
                    nxt = 1'b0;
                end
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop sync, counter debounce, press/release/long events, mode mux.
// Clean edge to press_pulse/level_out: DEBOUNCE_CYCLES+3 edges; mode/clear act next edge.
// No backpressure: events are single-cycle pulses that are never held off.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int CNT_W             = $clog2(LONG_PRESS_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    input  logic [1:0] mode,
    input  logic       clear,
    output logic       level_out,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    mode_e            mode_sel;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             st_q, st_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             level_q, level_d;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        sync1_d = button;
        sync2_d = sync1_q;

        dcnt_d   = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (dcnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        stable_dly_d = stable_q;
        press_d      = stable_q & ~stable_dly_q;
        release_d    = ~stable_q & stable_dly_q;

        // Hold counter follows the delayed level so long_pulse lands exactly
        // LONG_PRESS_CYCLES after press_pulse; saturation stops re-firing.
        hcnt_d = '0;
        long_d = 1'b0;
        if (stable_dly_q) begin
            if (hcnt_q != LP_MAX) begin
                hcnt_d = hcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q;
            end
            long_d = (hcnt_q == LP_LAST);
        end

        st_d = next_st(mode_sel, st_q, press_d, clear);

        level_d = 1'b0;
        case (mode_sel)
            MODE_MOMENTARY: level_d = stable_q;
            MODE_TOGGLE:    level_d = st_d;
            MODE_ONESHOT:   level_d = press_d;
            MODE_LATCH:     level_d = st_d;
            default:        level_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            st_q         <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            level_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            dcnt_q       <= dcnt_d;
            hcnt_q       <= hcnt_d;
            st_q         <= st_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            level_q      <= level_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// N independent pushbutton conditioners with per-channel mode and clear.
// Clean edge to press_pulse/level_out: DEBOUNCE_CYCLES+3 edges per channel.
// No backpressure: all outputs are free-running registered levels/pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS         = 2,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BUTTONS-1:0]   button,
    input  logic [2*N_BUTTONS-1:0] mode,
    input  logic [N_BUTTONS-1:0]   clear,
    output logic [N_BUTTONS-1:0]   level_out,
    output logic [N_BUTTONS-1:0]   press_pulse,
    output logic [N_BUTTONS-1:0]   release_pulse,
    output logic [N_BUTTONS-1:0]   long_pulse
);

    localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .CNT_W             (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .button        (button[i]),
            .mode          (mode[2*i +: 2]),
            .clear         (clear[i]),
            .level_out     (level_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner (N=2, DEBOUNCE=4, LONG=16):
// stimulus queues cycle-stamped expectations, a negedge monitor retires them.
module tb_button_conditioner;

    localparam logic [1:0] ALL = 2'b11;
    localparam logic [1:0] CH0 = 2'b01;
    localparam logic [1:0] CH1 = 2'b10;

    localparam int S_LEVEL = 0;
    localparam int S_PRESS = 1;
    localparam int S_REL   = 2;
    localparam int S_LONG  = 3;
    localparam int S_PCNT0 = 4;
    localparam int S_LCNT0 = 5;

    typedef struct {
        int         at;
        int         sig;
        logic [1:0] mask;
        int         val;
        string      name;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] button;
    logic [3:0] mode;
    logic [1:0] clear;
    logic [1:0] level_out;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    int press_cnt0 = 0;
    int long_cnt0  = 0;

    button_conditioner #(
        .N_BUTTONS         (2),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .mode          (mode),
        .clear         (clear),
        .level_out     (level_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic exp_at(input int at, input int sig, input logic [1:0] mask,
                          input int val, input string name);
        exp_t e;
        e.at   = at;
        e.sig  = sig;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_entry(input exp_t e);
        int act;
        int req;
        req = e.val & int'(e.mask);
        case (e.sig)
            S_LEVEL: act = int'(level_out & e.mask);
            S_PRESS: act = int'(press_pulse & e.mask);
            S_REL:   act = int'(release_pulse & e.mask);
            S_LONG:  act = int'(long_pulse & e.mask);
            S_PCNT0: begin act = press_cnt0; req = e.val; end
            S_LCNT0: begin act = long_cnt0;  req = e.val; end
            default: act = -1;
        endcase
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", e.name, cyc, act, req);
        end
    endtask

    // Monitor: counts pulses and retires every expectation due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                press_cnt0 = press_cnt0 + int'(press_pulse[0]);
                long_cnt0  = long_cnt0 + int'(long_pulse[0]);
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at < cyc) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL %s: stale, due cycle %0d, now %0d", sb[i].name, sb[i].at, cyc);
                    sb.delete(i);
                end else if (sb[i].at == cyc) begin
                    check_entry(sb[i]);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        int k;
        rst_n  = 1'b0;
        button = 2'b11;
        mode   = 4'b0000;
        clear  = 2'b00;

        // Reset held with both buttons down: everything stays quiet.
        tick(1);
        k = cyc;
        for (int j = 1; j <= 3; j++) begin
            exp_at(k + j, S_LEVEL, ALL, 0, "rst_level");
            exp_at(k + j, S_PRESS, ALL, 0, "rst_press_low");
            exp_at(k + j, S_LONG,  ALL, 0, "rst_long_low");
        end
        tick(4);
        k = cyc;
        rst_n = 1'b1;
        exp_at(k + 6, S_PRESS, ALL, 0, "rst_press_early");
        exp_at(k + 7, S_PRESS, ALL, 3, "rst_press");
        exp_at(k + 8, S_PRESS, ALL, 0, "rst_press_once");
        exp_at(k + 7, S_LEVEL, ALL, 3, "rst_level_up");
        tick(10);
        k = cyc;
        button = 2'b00;
        exp_at(k + 6, S_LEVEL, ALL, 3, "rst_level_hold");
        exp_at(k + 7, S_LEVEL, ALL, 0, "rst_level_down");
        exp_at(k + 7, S_REL,   ALL, 3, "rst_release");
        tick(12);

        // MOMENTARY ch0: 3-cycle glitch is ignored, then a 20-cycle hold.
        k = cyc;
        button[0] = 1'b1;
        tick(3);
        button[0] = 1'b0;
        exp_at(k + 7, S_PRESS, CH0, 0, "glitch_press");
        exp_at(k + 8, S_LEVEL, CH0, 0, "glitch_level");
        tick(12);
        exp_at(cyc + 1, S_PCNT0, ALL, 1, "glitch_press_count");
        tick(2);

        k = cyc;
        button[0] = 1'b1;
        exp_at(k + 6,  S_PRESS, CH0, 0, "mom_press_early");
        exp_at(k + 7,  S_PRESS, CH0, 1, "mom_press");
        exp_at(k + 8,  S_PRESS, CH0, 0, "mom_press_once");
        exp_at(k + 6,  S_LEVEL, CH0, 0, "mom_level_low");
        exp_at(k + 7,  S_LEVEL, CH0, 1, "mom_level_up");
        exp_at(k + 23, S_LONG,  CH0, 1, "mom_long");
        tick(20);
        k = cyc;
        button[0] = 1'b0;
        exp_at(k + 6, S_LEVEL, CH0, 1, "mom_level_hold");
        exp_at(k + 7, S_LEVEL, CH0, 0, "mom_level_down");
        exp_at(k + 7, S_REL,   CH0, 1, "mom_release");
        exp_at(k + 8, S_REL,   CH0, 0, "mom_release_once");
        tick(12);

        // TOGGLE ch1: two presses flip 0->1->0, then clear while set.
        for (int p = 0; p < 2; p++) begin
            k = cyc;
            if (p == 0) mode[3:2] = 2'd1;
            button[1] = 1'b1;
            exp_at(k + 6, S_LEVEL, CH1, (p == 0) ? 0 : 2, "tgl_before");
            exp_at(k + 7, S_LEVEL, CH1, (p == 0) ? 2 : 0, "tgl_after");
            tick(10);
            button[1] = 1'b0;
            tick(12);
            exp_at(cyc + 1, S_LEVEL, CH1, (p == 0) ? 2 : 0, "tgl_after_release");
            tick(2);
        end
        k = cyc;
        button[1] = 1'b1;
        exp_at(k + 7, S_LEVEL, CH1, 2, "tgl_third");
        tick(10);
        k = cyc;
        clear[1] = 1'b1;
        exp_at(k,     S_LEVEL, CH1, 2, "tgl_before_clear");
        exp_at(k + 1, S_LEVEL, CH1, 0, "tgl_clear");
        exp_at(k + 2, S_LEVEL, CH1, 0, "tgl_clear_holds");
        tick(1);
        clear[1] = 1'b0;
        button[1] = 1'b0;
        tick(12);

        // Long press: 40-cycle hold fires once, a 10-cycle hold never.
        k = cyc;
        button[0] = 1'b1;
        exp_at(k + 7,  S_PRESS, CH0, 1, "long_press");
        exp_at(k + 22, S_LONG,  CH0, 0, "long_early");
        exp_at(k + 23, S_LONG,  CH0, 1, "long_fire");
        exp_at(k + 24, S_LONG,  CH0, 0, "long_once");
        tick(40);
        button[0] = 1'b0;
        tick(12);
        exp_at(cyc + 1, S_LCNT0, ALL, 2, "long_count_40");
        tick(2);
        button[0] = 1'b1;
        tick(10);
        button[0] = 1'b0;
        tick(14);
        exp_at(cyc + 1, S_LCNT0, ALL, 2, "long_count_10");
        tick(2);

        // LATCH ch0: press coinciding with clear sets; clear alone resets.
        k = cyc;
        mode[1:0] = 2'd3;
        button[0] = 1'b1;
        exp_at(k + 6, S_LEVEL, CH0, 0, "latch_before");
        exp_at(k + 7, S_PRESS, CH0, 1, "latch_press_with_clear");
        exp_at(k + 7, S_LEVEL, CH0, 1, "latch_set_wins");
        exp_at(k + 9, S_LEVEL, CH0, 1, "latch_holds");
        tick(6);
        clear[0] = 1'b1;
        tick(1);
        clear[0] = 1'b0;
        tick(5);
        button[0] = 1'b0;
        tick(12);
        k = cyc;
        clear[0] = 1'b1;
        exp_at(k,     S_LEVEL, CH0, 1, "latch_before_clear");
        exp_at(k + 1, S_LEVEL, CH0, 0, "latch_clear");
        tick(1);
        clear[0] = 1'b0;
        tick(3);
        k = cyc;
        button[0] = 1'b1;
        exp_at(k + 7, S_LEVEL, CH0, 1, "latch_reset");
        tick(10);
        button[0] = 1'b0;
        tick(12);

        // ONESHOT ch0 with st=1 retained, then switch to TOGGLE mid-hold.
        k = cyc;
        mode[1:0] = 2'd2;
        button[0] = 1'b1;
        exp_at(k + 1,  S_LEVEL, CH0, 0, "os_idle");
        exp_at(k + 6,  S_LEVEL, CH0, 0, "os_before");
        exp_at(k + 7,  S_LEVEL, CH0, 1, "os_pulse");
        exp_at(k + 8,  S_LEVEL, CH0, 0, "os_once");
        exp_at(k + 12, S_LEVEL, CH0, 0, "os_low_held");
        tick(15);
        k = cyc;
        mode[1:0] = 2'd1;
        exp_at(k,     S_LEVEL, CH0, 0, "os_before_switch");
        exp_at(k + 1, S_LEVEL, CH0, 1, "tgl_retained_st");
        tick(15);
        button[0] = 1'b0;
        tick(12);

        for (int w = 0; w < 200 && sb.size() > 0; w++) begin
            tick(1);
        end
        while (sb.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never checked, due cycle %0d, now %0d", sb[0].name, sb[0].at, cyc);
            void'(sb.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the single-button press/toggle FSM.
- Each of N_BUTTONS raw pushbutton inputs passes through a 2-flop synchroniser and a counter-based debouncer.
- A per-channel output mode then selects momentary, toggle, one-shot or sticky-latch behaviour, and the block adds press, release and long-press event pulses.
- Sits between the board pushbutton pins and the key-fob control logic (code-generation trigger, mode select).

Parameters:
- N_BUTTONS, 2, number of independent button channels (1..16).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a new level (>=2).
- LONG_PRESS_CYCLES, 16, cycles a debounced press must be held before long_pulse fires (>DEBOUNCE_CYCLES).
- CNT_W, $clog2(LONG_PRESS_CYCLES+1), width of the per-channel counters (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- button  in  N_BUTTONS  raw, asynchronous, bouncy, active-high button levels.
- mode  in  2*N_BUTTONS  per-channel mode; channel i uses bits [2i+1:2i]. 0 = MOMENTARY, 1 = TOGGLE, 2 = ONESHOT, 3 = LATCH.
- clear  in  N_BUTTONS  synchronous per-channel clear of the toggle/latch state.
- level_out  out  N_BUTTONS  conditioned per-channel output; registered.
- press_pulse  out  N_BUTTONS  1-cycle pulse on each debounced press.
- release_pulse  out  N_BUTTONS  1-cycle pulse on each debounced release.
- long_pulse  out  N_BUTTONS  1-cycle pulse once per press when the hold reaches LONG_PRESS_CYCLES.

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser flops, stable levels, counters, toggle/latch state and every output go to 0. Outputs stay 0 until the first debounced event after release.
- Synchroniser: 2 flops per channel. The synchronised level b_s lags button by 2 edges.
- Debounce counter (dcnt):
  - b_s == stable: dcnt <= 0.
  - b_s != stable and dcnt < DEBOUNCE_CYCLES-1: dcnt increments.
  - b_s != stable and dcnt == DEBOUNCE_CYCLES-1: stable <= b_s, dcnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
- Events, registered from stable vs stable_d:
  - press_pulse = stable & ~stable_d.
  - release_pulse = ~stable & stable_d.
  - End-to-end latency, clean edge to press_pulse high: DEBOUNCE_CYCLES+3 clock edges.
- Long-press counter (hcnt):
  - Cleared when stable == 0.
  - Increments while stable == 1 and saturates at LONG_PRESS_CYCLES.
  - long_pulse fires for exactly one cycle on the edge where hcnt reaches LONG_PRESS_CYCLES. It does not re-fire until release followed by a new press.
- Per-channel state bit st; clear has priority over toggling:
  - TOGGLE: st flips on press; clear forces 0.
  - LATCH: st sets on press; clear resets it. Press and clear in the same cycle gives st = 1 (set wins).
- level_out, registered, selected by the current mode:
  - MOMENTARY: stable.
  - TOGGLE: st.
  - ONESHOT: press_pulse, i.e. high for one cycle per press.
  - LATCH: st.
- Mode change: takes effect on level_out the next cycle. st is retained across mode changes, so switching to TOGGLE shows the existing st. Events are independent of mode.
- Reset mid-press: all state clears. If the button is still held after reset release, a fresh press_pulse occurs DEBOUNCE_CYCLES+3 edges later.
- Channels are fully independent; simultaneous events on different channels all appear in the same cycle.

Decomposition:
- Shared package button_pkg:
  - Mode enum: MODE_MOMENTARY = 2'd0, MODE_TOGGLE = 2'd1, MODE_ONESHOT = 2'd2, MODE_LATCH = 2'd3.
  - Default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants.
- One natural sub-module, button_channel, covering a single channel: synchroniser, debouncer, event detect, long-press counter and mode mux.
- The top instantiates N_BUTTONS copies through a generate loop and slices mode.

Test Plan:
- Reset, N_BUTTONS=2, DEBOUNCE=4, LONG=16: hold rst_n low with button=2'b11 -> all outputs 0 during reset. After release, press_pulse=2'b11 exactly 7 edges later.
- MOMENTARY channel 0: button high for 3 synchronised cycles, then low -> no press_pulse, level_out[0] stays 0. Then hold 20 cycles -> press_pulse[0] one cycle at edge 7, level_out[0]=1; release -> release_pulse[0] one cycle, level_out[0]=0 seven edges after the fall.
- TOGGLE channel 1: two separate clean presses -> level_out[1] goes 0->1 after the first and 1->0 after the second. Assert clear[1] while at 1 -> level_out[1]=0 the cycle after.
- Long press: hold channel 0 for 40 cycles -> exactly one long_pulse[0], 16 cycles after press_pulse[0], and none afterwards. A 10-cycle press -> no long_pulse.
- LATCH with simultaneous events: press_pulse[0] and clear[0] in the same cycle -> level_out[0]=1. clear alone -> 0.
- ONESHOT: hold button 30 cycles -> level_out high for exactly 1 cycle. Switching mode to TOGGLE mid-hold -> level_out shows the retained st value the next cycle.
